// File: rtl/key_debouncer_pkg.sv
// key_debouncer_pkg
//   Shared types and default constants for the push-button debouncer.
//   key_state_t : debounce FSM states
//   KEY_*_DEFAULT : default cycle counts (50 MHz system clock)
//   max_int : helper for sizing counters from two parameters
package key_debouncer_pkg;

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_CHECK,
    PRESSED,
    RELEASE_CHECK
  } key_state_t;

  // 20 ms of stable input at 50 MHz
  localparam int KEY_DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
  // 500 ms hold before the first auto-repeat strobe
  localparam int KEY_REPEAT_DELAY_DEFAULT    = 25_000_000;
  // 100 ms between subsequent auto-repeat strobes
  localparam int KEY_REPEAT_PERIOD_DEFAULT   = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// key_debouncer_if
//   Groups the key input and the debounced outputs.
//   key_n       : raw active-low push-button (driven by the board side)
//   key_pressed : one-cycle strobe per accepted press
//   key_held    : debounced level, 1 while the key is considered pressed
//   modport master : board/consumer side (drives key_n, reads outputs)
//   modport slave  : debouncer side
interface key_debouncer_if;
  logic key_n;
  logic key_pressed;
  logic key_held;

  modport master (output key_n, input key_pressed, input key_held);
  modport slave  (input key_n, output key_pressed, output key_held);
endinterface

// File: rtl/input_synchronizer.sv
// input_synchronizer
//   Two-flop synchroniser for asynchronous board inputs, one chain per bit.
//   clock : destination clock
//   reset : synchronous active-high reset, loads RESET_VALUE into both stages
//   din   : asynchronous input bits
//   dout  : synchronised bits (second stage)
module input_synchronizer #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sync
    logic s1_reg;
    logic s2_reg;

    always_ff @(posedge clock) begin
      if (reset) begin
        s1_reg <= RESET_VALUE[gi];
        s2_reg <= RESET_VALUE[gi];
      end else begin
        s1_reg <= din[gi];
        s2_reg <= s1_reg;
      end
    end

    assign dout[gi] = s2_reg;
  end

endmodule

// File: rtl/key_debouncer.sv
// key_debouncer
//   Synchronises and debounces the inverted manual-clock push-button and
//   produces a one-cycle press strobe plus a debounced held level.
//   clock  : system clock, all state changes on its rising edge
//   reset  : synchronous active-high reset
//   key_if : slave side of key_debouncer_if (key_n in, key_pressed/key_held out)
//   Optional build macro KEY_DEBOUNCER_AUTOREPEAT_EN adds auto-repeat strobes
//   while the key stays pressed (first after REPEAT_DELAY cycles, then every
//   REPEAT_PERIOD cycles).
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEFAULT,
  parameter int REPEAT_DELAY    = KEY_REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = KEY_REPEAT_PERIOD_DEFAULT
) (
  input logic            clock,
  input logic            reset,
  key_debouncer_if.slave key_if
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_n_sync;
  key_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             pressed_reg, pressed_next;
  logic             held_reg, held_next;
  logic             accept_press;

  // Released (1) is the safe idle value, so a key held through reset is
  // seen as a fresh press once reset lifts.
  input_synchronizer #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_key_sync (
    .clock (clock),
    .reset (reset),
    .din   (key_if.key_n),
    .dout  (key_n_sync)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= RELEASED;
      cnt_reg     <= '0;
      pressed_reg <= 1'b0;
      held_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      pressed_reg <= pressed_next;
      held_reg    <= held_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    accept_press = 1'b0;
    case (state_reg)
      RELEASED: begin
        if (!key_n_sync) begin
          state_next = PRESS_CHECK;
          cnt_next   = '0;
        end
      end
      PRESS_CHECK: begin
        if (key_n_sync) begin
          state_next = RELEASED;        // bounce: drop it silently
        end else if (cnt_reg == CNT_LAST) begin
          state_next   = PRESSED;
          accept_press = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PRESSED: begin
        if (key_n_sync) begin
          state_next = RELEASE_CHECK;
          cnt_next   = '0;
        end
      end
      RELEASE_CHECK: begin
        if (!key_n_sync) begin
          state_next = PRESSED;         // glitch while held: no new strobe
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RELEASED;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = RELEASED;
        cnt_next   = '0;
      end
    endcase
    held_next = (state_next == PRESSED) || (state_next == RELEASE_CHECK);
  end

`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [RPT_W-1:0] rpt_cnt_reg, rpt_cnt_next;
  logic             rpt_first_reg, rpt_first_next;
  logic [RPT_W-1:0] rpt_limit;
  logic             rpt_fire;

  always_ff @(posedge clock) begin
    if (reset) begin
      rpt_cnt_reg   <= '0;
      rpt_first_reg <= 1'b1;
    end else begin
      rpt_cnt_reg   <= rpt_cnt_next;
      rpt_first_reg <= rpt_first_next;
    end
  end

  // The counter only advances while the key stays in PRESSED; it holds its
  // value through RELEASE_CHECK so a short glitch does not restart the delay.
  always_comb begin
    rpt_cnt_next   = rpt_cnt_reg;
    rpt_first_next = rpt_first_reg;
    rpt_fire       = 1'b0;
    rpt_limit      = rpt_first_reg ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
    if (accept_press) begin
      rpt_cnt_next   = '0;
      rpt_first_next = 1'b1;
    end else if (state_reg == PRESSED && state_next == PRESSED) begin
      if (rpt_cnt_reg == rpt_limit) begin
        rpt_fire       = 1'b1;
        rpt_cnt_next   = '0;
        rpt_first_next = 1'b0;
      end else begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end
  end

  assign pressed_next = accept_press | rpt_fire;
`else
  // Repeat timing parameters have no effect in this build.
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = 32'(REPEAT_DELAY + REPEAT_PERIOD);
  assign pressed_next      = accept_press;
`endif

  assign key_if.key_pressed = pressed_reg;
  assign key_if.key_held    = held_reg;

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer
//   Directed stimulus for key_debouncer with DEBOUNCE_CYCLES=4,
//   REPEAT_DELAY=10, REPEAT_PERIOD=3. Stimulus pushes the edge numbers at
//   which strobes and key_held changes are due; a monitor on the falling
//   edge pops and compares them as the outputs move.
//   With DEBOUNCE_CYCLES=4 an accepted level change shows up at the edge
//   6 after the first edge that samples the new key_n level (edge 1 -> 7).
module tb_key_debouncer;

  logic clock;
  logic reset;
  int   edge_cnt;
  int   checks;
  int   errors;

  typedef struct {
    int cyc;
    bit val;
  } held_ev_t;

  int       sq[$];
  held_ev_t hq[$];
  bit       prev_held;

  key_debouncer_if bus ();

  key_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (3)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .key_if (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_held(input int c, input bit v);
    held_ev_t ev;
    ev.cyc = c;
    ev.val = v;
    hq.push_back(ev);
  endtask

  // Monitor: outputs are registered at edge edge_cnt and sampled here.
  initial prev_held = 1'b0;
  always @(negedge clock) begin
    int       exp_e;
    held_ev_t he;
    if (sq.size() > 0 && sq[0] < edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL strobe_missing: actual none, required strobe at edge %0d (now edge %0d)",
               sq[0], edge_cnt);
      void'(sq.pop_front());
    end
    if (key_pressed_w === 1'b1) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: actual strobe at edge %0d, required none", edge_cnt);
      end else begin
        exp_e = sq.pop_front();
        if (exp_e != edge_cnt) begin
          errors++;
          $display("FAIL strobe_edge: actual edge %0d, required edge %0d", edge_cnt, exp_e);
        end else begin
          $display("edge %0d: key_pressed strobe ok", edge_cnt);
        end
      end
    end
    if (hq.size() > 0 && hq[0].cyc < edge_cnt) begin
      checks++;
      errors++;
      $display("FAIL held_missing: actual key_held=%0b, required %0b at edge %0d (now edge %0d)",
               key_held_w, hq[0].val, hq[0].cyc, edge_cnt);
      void'(hq.pop_front());
    end
    if (key_held_w !== prev_held) begin
      checks++;
      if (hq.size() == 0) begin
        errors++;
        $display("FAIL held_unexpected: actual key_held=%0b at edge %0d, required %0b",
                 key_held_w, edge_cnt, prev_held);
      end else begin
        he = hq.pop_front();
        if (he.cyc != edge_cnt || he.val !== key_held_w) begin
          errors++;
          $display("FAIL held_edge: actual key_held=%0b at edge %0d, required %0b at edge %0d",
                   key_held_w, edge_cnt, he.val, he.cyc);
        end else begin
          $display("edge %0d: key_held -> %0b ok", edge_cnt, key_held_w);
        end
      end
      prev_held = key_held_w;
    end
  end

  logic key_pressed_w;
  logic key_held_w;
  assign key_pressed_w = bus.key_pressed;
  assign key_held_w    = bus.key_held;

  initial begin
    int b;
    int r;
    bit pat [8];
    checks = 0;
    errors = 0;
    pat    = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    // Reset, outputs must be low
    bus.key_n = 1'b1;
    reset     = 1'b1;
    tick(3);
    reset = 1'b0;
    checks++;
    if (bus.key_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_pressed: actual %b, required 0", bus.key_pressed);
    end else $display("reset: key_pressed=0 ok");
    checks++;
    if (bus.key_held !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: actual %b, required 0", bus.key_held);
    end else $display("reset: key_held=0 ok");

    // Idle released for 20 cycles: the monitor flags any activity
    tick(20);

    // Clean press, 19 cycles low, then release
    b = edge_cnt + 1;
    sq.push_back(b + 6);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    sq.push_back(b + 16);
    sq.push_back(b + 19);
`endif
    push_held(b + 6, 1'b1);
    bus.key_n = 1'b0;
    tick(19);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    // Bounce pattern: never stable for 4 cycles, nothing expected
    foreach (pat[i]) begin
      bus.key_n = pat[i];
      tick(1);
    end
    bus.key_n = 1'b1;
    tick(20);

    // Press (also proves the FSM is back in RELEASED), 2-cycle glitch mid-hold
    b = edge_cnt + 1;
    sq.push_back(b + 6);
    push_held(b + 6, 1'b1);
    bus.key_n = 1'b0;
    tick(8);
    bus.key_n = 1'b1;
    tick(2);
    bus.key_n = 1'b0;
    tick(3);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    // Reset at edge 5 (mid PRESS_CHECK) with key kept low
    b = edge_cnt + 1;
    bus.key_n = 1'b0;
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sq.push_back(b + 11);
    push_held(b + 11, 1'b1);
    tick(8);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    // Reset while PRESSED: key_held drops at the reset edge, then a new press
    b = edge_cnt + 1;
    sq.push_back(b + 6);
    push_held(b + 6, 1'b1);
    bus.key_n = 1'b0;
    tick(8);
    reset = 1'b1;
    push_held(b + 8, 1'b0);
    tick(1);
    reset = 1'b0;
    sq.push_back(b + 15);
    push_held(b + 15, 1'b1);
    tick(8);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    // Reset on the accepting edge: the pending strobe is discarded
    b = edge_cnt + 1;
    bus.key_n = 1'b0;
    tick(6);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    sq.push_back(b + 13);
    push_held(b + 13, 1'b1);
    tick(8);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    // Long hold: repeat strobes after edges 17,20,23,26,29 when enabled
    b = edge_cnt + 1;
    sq.push_back(b + 6);
`ifdef KEY_DEBOUNCER_AUTOREPEAT_EN
    sq.push_back(b + 16);
    sq.push_back(b + 19);
    sq.push_back(b + 22);
    sq.push_back(b + 25);
    sq.push_back(b + 28);
`endif
    push_held(b + 6, 1'b1);
    bus.key_n = 1'b0;
    tick(28);
    r = edge_cnt + 1;
    push_held(r + 6, 1'b0);
    bus.key_n = 1'b1;
    tick(20);

    tick(5);
    checks++;
    if (sq.size() != 0) begin
      errors++;
      $display("FAIL strobe_queue_end: actual %0d pending strobes, required 0", sq.size());
    end else $display("end: all strobes seen");
    checks++;
    if (hq.size() != 0) begin
      errors++;
      $display("FAIL held_queue_end: actual %0d pending held changes, required 0", hq.size());
    end else $display("end: all key_held changes seen");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_debouncer.md
Name: key_debouncer

Overview:
- Upstream input stage for the manual clock path of the 8-bit MCU.
- Takes the raw, bouncing, inverted push-button `key_n` and synchronises it.
- Debounces it with a counter-based FSM and emits a single-cycle `key_pressed` strobe per physical press, plus a debounced level `key_held`.
- Its outputs drive the control unit's manual-step input.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable cycles required to accept a level change (20 ms at 50 MHz); legal range 2..2^24-1.
- REPEAT_DELAY, 25_000_000, cycles held in PRESSED before the first auto-repeat strobe (used only with the optional feature).
- REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeat strobes (used only with the optional feature).

Ports:
- clock  input  1  50 MHz system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- key_n  input  1  raw push-button, active-low, asynchronous to clock.
- key_pressed  output  1  one-cycle strobe per accepted press (registered).
- key_held  output  1  debounced level, 1 while the key is considered pressed (registered).

Behaviour:
- Interface decision: one clock, `clock`; reset is synchronous and active-high, port `reset`.
- Synchroniser: two flops, `key_n` -> s1 -> s2; both reset to 1 (released). The FSM uses s2 only.
- Debounce counter `cnt`: width $clog2(DEBOUNCE_CYCLES); cleared on every entry to a CHECK state. Counting never wraps: it stops at DEBOUNCE_CYCLES-1, where a transition occurs.
- FSM states: RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK.
  - RELEASED: s2=0 -> PRESS_CHECK, cnt<=0.
  - PRESS_CHECK: s2=1 -> RELEASED (bounce rejected, no strobe); else if cnt==DEBOUNCE_CYCLES-1 -> PRESSED and key_pressed<=1; else cnt++.
  - PRESSED: s2=1 -> RELEASE_CHECK, cnt<=0.
  - RELEASE_CHECK: s2=0 -> PRESSED (glitch, no new strobe); else if cnt==DEBOUNCE_CYCLES-1 -> RELEASED; else cnt++.
- key_pressed: 1 for exactly one cycle, in the cycle after the PRESSED-entering edge; 0 otherwise.
- key_held: 1 in PRESSED and RELEASE_CHECK.
- Latency: with edge 1 being the first edge that samples key_n=0, and key_n then stable, the transition to PRESSED happens at edge DEBOUNCE_CYCLES+3. Release latency is the same.
- Reset (any time, including mid-CHECK):
  - next cycle: state=RELEASED, cnt=0, s1=s2=1, key_pressed=0, key_held=0, repeat counter=0;
  - any pending strobe is discarded;
  - a key held through reset is treated as a new press after reset deasserts and yields one strobe after the full latency.
- No combinational path from key_n to any output.

Optional Feature:
- Macro: KEY_DEBOUNCER_AUTOREPEAT_EN.
- Defined:
  - a repeat counter clears on entry to PRESSED from PRESS_CHECK;
  - it increments in PRESSED and freezes in RELEASE_CHECK, so a glitch does not restart the delay;
  - the first extra strobe occurs REPEAT_DELAY cycles after PRESSED entry, then one every REPEAT_PERIOD cycles while held;
  - each strobe is one cycle wide.
- Undefined: repeat logic is absent and there is exactly one strobe per press.

Decomposition:
- Package def:
  - typedef enum logic[1:0] key_state_t {RELEASED, PRESS_CHECK, PRESSED, RELEASE_CHECK};
  - default constants KEY_DEBOUNCE_CYCLES_DEFAULT, KEY_REPEAT_DELAY_DEFAULT, KEY_REPEAT_PERIOD_DEFAULT.
- Sub-module: input_synchronizer, a 2-flop synchroniser with a reset value parameter, reusable for other board inputs. Everything else stays in key_debouncer.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3):
1. Reset 3 cycles, then key_n=1 for 20 cycles -> key_pressed=0 and key_held=0 throughout.
2. key_n=0 from edge 1, held for 20 cycles -> key_pressed high only in the cycle after edge 7; key_held=1 from edge 7. Then key_n=1 -> key_held falls 7 edges later.
3. Bounce: key_n pattern 0,0,1,0,0,1,0,1 and then 1 -> no strobe; key_held stays 0; FSM returns to RELEASED.
4. Press accepted, then key_n=1 for 2 cycles mid-hold -> key_held stays 1 and no second strobe.
5. key_n=0, reset asserted at edge 5 (mid PRESS_CHECK) for 1 cycle, key_n kept 0 -> no strobe before reset; after reset deasserts, one strobe appears 7 edges later.
6. Macro defined, key_n=0 held 30 cycles -> strobes after edges 7, 17, 20, 23, 26, 29. Macro undefined, same stimulus -> strobe after edge 7 only.
